// File: rtl/draw_pkg.sv
// Shared constants and types for the line-draw command scheduler.
package draw_pkg;

    localparam int unsigned COORD_W = 9;

    localparam logic KIND_H = 1'b0;
    localparam logic KIND_V = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2,
        StGap    = 2'd3
    } state_e;

    // Command word layout: {kind, a1, a2, b}
    function automatic int unsigned cmd_width(input int unsigned coord_w);
        return 1 + 3 * coord_w;
    endfunction

    localparam int unsigned CMD_W = 1 + 3 * COORD_W;

endpackage

// File: rtl/draw_cmd_fifo.sv
// Synchronous command FIFO; power-of-two depth so pointers wrap naturally.
module draw_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 28
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_wr, do_rd;

    assign o_full    = (count_q == CW'(DEPTH));
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_rd_data = mem_q[rd_ptr_q];

    assign do_wr = i_wr_en && !o_full;
    assign do_rd = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_draw_scheduler.sv
// Queues H/V segment requests, launches one engine at a time and hands it the SPI pins,
// with a CS-high gap between commands and a done watchdog.
module spi_draw_scheduler #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned COORD_W    = 9,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 16_777_215
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_kind,
    input  logic [COORD_W-1:0] i_req_a1,
    input  logic [COORD_W-1:0] i_req_a2,
    input  logic [COORD_W-1:0] i_req_b,
    output logic               o_h_start,
    output logic               o_v_start,
    output logic [COORD_W-1:0] o_h_x1,
    output logic [COORD_W-1:0] o_h_x2,
    output logic [COORD_W-1:0] o_h_y,
    output logic [COORD_W-1:0] o_v_y1,
    output logic [COORD_W-1:0] o_v_y2,
    output logic [COORD_W-1:0] o_v_x,
    input  logic               i_h_done,
    input  logic               i_v_done,
    input  logic               i_h_mosi,
    input  logic               i_h_dc,
    input  logic               i_h_cs,
    input  logic               i_v_mosi,
    input  logic               i_v_dc,
    input  logic               i_v_cs,
    output logic               o_mosi,
    output logic               o_dc,
    output logic               o_cs,
    output logic               o_done,
    output logic               o_err,
    output logic               o_busy
);

    import draw_pkg::*;

    localparam int unsigned CMD_BITS = cmd_width(COORD_W);
    localparam int unsigned OPS_BITS = 3 * COORD_W;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [23:0]      WDOG_LAST = (TIMEOUT == 0) ? 24'd0 : 24'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [OPS_BITS-1:0]   ops_q, ops_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [23:0]           wdog_q, wdog_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  fifo_full, fifo_empty, fifo_rd;
    logic [CMD_BITS-1:0]   fifo_rd_data;
    logic [$clog2(DEPTH):0] fifo_count;

    logic                  req_hs, req_degen, owner_done, active, h_active, v_active;

    assign o_req_ready = !fifo_full;
    assign req_hs      = i_req_valid && !fifo_full;
    assign req_degen   = (i_req_a2 < i_req_a1);

    draw_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_BITS)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (req_hs && !req_degen),
        .i_wr_data ({i_req_kind, i_req_a1, i_req_a2, i_req_b}),
        .i_rd_en   (fifo_rd),
        .o_rd_data (fifo_rd_data),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_count   (fifo_count)
    );

    assign owner_done = (owner_q == KIND_V) ? i_v_done : i_h_done;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ops_d   = ops_q;
        gap_d   = gap_q;
        wdog_d  = wdog_q;
        done_d  = 1'b0;
        err_d   = req_hs && req_degen;
        fifo_rd = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    owner_d = fifo_rd_data[CMD_BITS-1];
                    ops_d   = fifo_rd_data[OPS_BITS-1:0];
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                // Done is checked first so it beats a simultaneous expiry.
                if (owner_done) begin
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = StGap;
                end else if (TIMEOUT != 0 && wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    wdog_d = wdog_q + 24'd1;
                end
            end
            StGap: begin
                if (gap_q == GAP_LAST) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= StIdle;
            owner_q <= KIND_H;
            ops_q   <= '0;
            gap_q   <= '0;
            wdog_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ops_q   <= ops_d;
            gap_q   <= gap_d;
            wdog_q  <= wdog_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign active   = (state_q == StLaunch) || (state_q == StWait);
    assign h_active = active && (owner_q == KIND_H);
    assign v_active = active && (owner_q == KIND_V);

    assign o_h_start = (state_q == StLaunch) && (owner_q == KIND_H);
    assign o_v_start = (state_q == StLaunch) && (owner_q == KIND_V);

    assign o_h_x1 = h_active ? ops_q[3*COORD_W-1 -: COORD_W] : '0;
    assign o_h_x2 = h_active ? ops_q[2*COORD_W-1 -: COORD_W] : '0;
    assign o_h_y  = h_active ? ops_q[COORD_W-1:0]            : '0;
    assign o_v_y1 = v_active ? ops_q[3*COORD_W-1 -: COORD_W] : '0;
    assign o_v_y2 = v_active ? ops_q[2*COORD_W-1 -: COORD_W] : '0;
    assign o_v_x  = v_active ? ops_q[COORD_W-1:0]            : '0;

    // Outside an owned command the bus rests deselected.
    assign o_mosi = h_active ? i_h_mosi : (v_active ? i_v_mosi : 1'b0);
    assign o_dc   = h_active ? i_h_dc   : (v_active ? i_v_dc   : 1'b0);
    assign o_cs   = h_active ? i_h_cs   : (v_active ? i_v_cs   : 1'b1);

    assign o_done = done_q;
    assign o_err  = err_q;
    assign o_busy = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_spi_draw_scheduler.sv
// Directed bench for spi_draw_scheduler (DEPTH 4, GAP 2, TIMEOUT 100).
module tb_spi_draw_scheduler;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_req_valid = 1'b0;
    logic       i_req_kind = 1'b0;
    logic [8:0] i_req_a1 = '0, i_req_a2 = '0, i_req_b = '0;
    logic       i_h_done = 1'b0, i_v_done = 1'b0;
    logic       i_h_mosi = 1'b0, i_h_dc = 1'b0, i_h_cs = 1'b1;
    logic       i_v_mosi = 1'b0, i_v_dc = 1'b0, i_v_cs = 1'b1;
    logic       o_req_ready, o_h_start, o_v_start;
    logic [8:0] o_h_x1, o_h_x2, o_h_y, o_v_y1, o_v_y2, o_v_x;
    logic       o_mosi, o_dc, o_cs, o_done, o_err, o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    spi_draw_scheduler #(
        .DEPTH      (4),
        .COORD_W    (9),
        .GAP_CYCLES (2),
        .TIMEOUT    (100)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_kind  (i_req_kind),
        .i_req_a1    (i_req_a1),
        .i_req_a2    (i_req_a2),
        .i_req_b     (i_req_b),
        .o_h_start   (o_h_start),
        .o_v_start   (o_v_start),
        .o_h_x1      (o_h_x1),
        .o_h_x2      (o_h_x2),
        .o_h_y       (o_h_y),
        .o_v_y1      (o_v_y1),
        .o_v_y2      (o_v_y2),
        .o_v_x       (o_v_x),
        .i_h_done    (i_h_done),
        .i_v_done    (i_v_done),
        .i_h_mosi    (i_h_mosi),
        .i_h_dc      (i_h_dc),
        .i_h_cs      (i_h_cs),
        .i_v_mosi    (i_v_mosi),
        .i_v_dc      (i_v_dc),
        .i_v_cs      (i_v_cs),
        .o_mosi      (o_mosi),
        .o_dc        (o_dc),
        .o_cs        (o_cs),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic kind, input int a1, input int a2, input int b);
        i_req_valid = 1'b1;
        i_req_kind  = kind;
        i_req_a1    = 9'(a1);
        i_req_a2    = 9'(a2);
        i_req_b     = 9'(b);
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_cs"},   o_cs, 1);
        chk({tag, "_mosi"}, o_mosi, 0);
        chk({tag, "_dc"},   o_dc, 0);
        chk({tag, "_start"}, {o_h_start, o_v_start}, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_err"},  o_err, 0);
        chk({tag, "_ready"}, o_req_ready, 1);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_ops"},  {o_h_x1, o_h_x2, o_h_y, o_v_y1, o_v_y2, o_v_x}, 0);
    endtask

    // Waits for the next launch, checks it, then completes it via the owner's done.
    task automatic expect_cmd(input logic kind, input int a1, input int a2, input int b);
        int k = 0;
        while (!(o_h_start || o_v_start) && k < 20) begin
            cyc();
            k++;
        end
        chk("start_seen", o_h_start | o_v_start, 1);
        chk("start_kind", {o_h_start, o_v_start}, kind ? 2'b01 : 2'b10);
        if (kind) chk("v_ops", {o_v_y1, o_v_y2, o_v_x}, {9'(a1), 9'(a2), 9'(b)});
        else      chk("h_ops", {o_h_x1, o_h_x2, o_h_y}, {9'(a1), 9'(a2), 9'(b)});
        cyc();
        if (kind) begin i_v_cs = 1'b0; i_v_mosi = 1'b1; end
        else      begin i_h_cs = 1'b0; i_h_mosi = 1'b1; end
        #1;
        chk("owner_pins", {o_cs, o_mosi}, 2'b01);
        if (kind) i_v_done = 1'b1; else i_h_done = 1'b1;
        cyc();
        i_h_done = 1'b0; i_v_done = 1'b0;
        i_h_cs = 1'b1; i_v_cs = 1'b1; i_h_mosi = 1'b0; i_v_mosi = 1'b0;
        #1;
        chk("cmd_done", {o_done, o_cs}, 2'b11);
    endtask

    initial begin
        int seen;
        // Reset
        repeat (3) cyc();
        chk_idle_pins("reset");
        i_rst = 1'b1;
        cyc();

        // Single horizontal command
        push(1'b0, 10, 20, 5);
        #1;
        chk("single_ready", o_req_ready, 1);
        cyc();
        i_req_valid = 1'b0;
        chk("single_n1_start", o_h_start, 0);
        chk("single_n1_busy", o_busy, 1);
        cyc();
        chk("single_start", {o_h_start, o_v_start}, 2'b10);
        chk("single_ops", {o_h_x1, o_h_x2, o_h_y}, {9'd10, 9'd20, 9'd5});
        chk("single_vops", {o_v_y1, o_v_y2, o_v_x}, 0);
        i_h_mosi = 1'b1; i_h_dc = 1'b1; i_h_cs = 1'b0;
        #1;
        chk("single_pins", {o_mosi, o_dc, o_cs}, 3'b110);
        cyc();
        chk("single_wait_start", o_h_start, 0);
        chk("single_wait_ops", o_h_x2, 20);
        i_h_done = 1'b1;
        cyc();
        i_h_done = 1'b0;
        #1;
        chk("single_done", o_done, 1);
        chk("single_gap1_pins", {o_mosi, o_dc, o_cs}, 3'b001);
        cyc();
        chk("single_gap2", {o_done, o_cs}, 2'b01);
        cyc();
        i_h_mosi = 1'b0; i_h_dc = 1'b0; i_h_cs = 1'b1;
        #1;
        chk("single_idle_busy", o_busy, 0);

        // Degenerate request
        push(1'b0, 30, 29, 7);
        #1;
        chk("degen_ready", o_req_ready, 1);
        cyc();
        i_req_valid = 1'b0;
        chk("degen_err", o_err, 1);
        chk("degen_busy", o_busy, 0);
        cyc();
        chk("degen_err_pulse", o_err, 0);
        cyc();
        chk("degen_no_start", {o_h_start, o_v_start}, 0);

        // Timeout with stray non-owner done, then the queued command launches
        push(1'b0, 1, 2, 3);
        cyc();
        i_req_valid = 1'b0;
        cyc();
        chk("to_start", o_h_start, 1);
        cyc();
        i_h_cs = 1'b0;
        i_v_done = 1'b1;
        push(1'b1, 7, 9, 4);
        cyc();
        i_v_done = 1'b0;
        i_req_valid = 1'b0;
        #1;
        chk("stray_done", {o_done, o_err, o_cs}, 3'b000);
        repeat (98) cyc();
        chk("to_last_wait", {o_err, o_cs}, 2'b00);
        cyc();
        chk("to_err", {o_err, o_done, o_cs}, 3'b101);
        i_h_cs = 1'b1;
        cyc();
        chk("to_err_pulse", o_err, 0);
        cyc();
        chk("to_gap_no_start", {o_h_start, o_v_start}, 0);
        cyc();
        chk("to_next_start", {o_h_start, o_v_start}, 2'b01);
        chk("to_next_ops", {o_v_y1, o_v_y2, o_v_x}, {9'd7, 9'd9, 9'd4});
        chk("to_next_hops", o_h_x1, 0);
        cyc();
        i_v_done = 1'b1;
        cyc();
        i_v_done = 1'b0;
        #1;
        chk("to_next_done", o_done, 1);
        repeat (3) cyc();

        // Fill: head command stalls while four more queue up
        push(1'b0, 0, 8, 1);
        cyc();
        i_req_valid = 1'b0;
        cyc();
        chk("fill_c0_start", o_h_start, 1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            push((i % 2) == 0, i * 10, i * 10 + 5, i + 40);
            #1;
            chk("fill_ready", o_req_ready, 1);
            cyc();
        end
        push(1'b1, 100, 110, 50);
        #1;
        chk("fill_full", {o_req_ready, o_busy}, 2'b01);
        chk("fill_no_overlap", o_v_start, 0);
        i_h_done = 1'b1;
        cyc();
        i_h_done = 1'b0;
        i_req_valid = 1'b0;
        #1;
        chk("fill_c0_done", o_done, 1);
        expect_cmd(1'b1, 0, 5, 40);
        expect_cmd(1'b0, 10, 15, 41);
        expect_cmd(1'b1, 20, 25, 42);
        expect_cmd(1'b0, 30, 35, 43);
        repeat (3) cyc();
        chk("fill_drained", o_busy, 0);

        // Reset in WAIT with two queued commands
        push(1'b0, 1, 1, 1);
        cyc();
        i_req_valid = 1'b0;
        cyc();
        chk("rst_mid_start", o_h_start, 1);
        cyc();
        i_h_cs = 1'b0; i_h_mosi = 1'b1;
        push(1'b1, 2, 3, 4);
        cyc();
        push(1'b0, 5, 6, 7);
        cyc();
        i_req_valid = 1'b0;
        i_rst = 1'b0;
        cyc();
        i_h_cs = 1'b1; i_h_mosi = 1'b0;
        #1;
        chk_idle_pins("rst_mid");
        i_rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (o_h_start || o_v_start || o_done) seen++;
        end
        chk("rst_mid_no_launch", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
